axil_master: RTL and testbench

- Bridges the core's simple single-outstanding load/store request bus to an AXI4-Lite master port.
- Drives the sysio slave and any peer AXI4-Lite slave that uses the same channel set: AW, W, AR and R, with no B channel.
- Sits between the core's peripheral-region decode and the sysio block.
- Sequences address/data handshakes, returns read data, and converts a hung slave into an error response through a timeout.

---
 rtl/axil_master_pkg.sv | 10 +
 rtl/axil_master.sv | 213 +++++++++++++++++++++
 tb/tb_axil_master.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_master_pkg.sv
// Shared bus widths for the core-to-AXI4-Lite bridge.
// Kept in step with the core's memory bus definitions. The data bus is
// 32 bits, the byte address is 32 bits, and there is one strobe per data byte.
package axil_master_pkg;

  localparam int unsigned MemBusW  = 32;
  localparam int unsigned MemAddrW = 32;
  localparam int unsigned StrbW    = MemBusW / 8;

endpackage

// File: rtl/axil_master.sv
// axil_master: bridges the core's single-outstanding load/store bus to an
// AXI4-Lite master port. The port uses the AW, W, AR and R channels and has
// no B channel. A stalled channel is aborted after TIMEOUT cycles, and the
// abort is reported as an error acknowledge.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_i/we_i/addr_i/    core request; sampled only while idle
//   wdata_i/sel_i
//   rdata_o/ack_o/err_o   completion: one-cycle ack, err coincident on timeout
//   busy_o                high whenever a transfer is in flight
//   m_axi_aw*/w*/ar*/r*   AXI4-Lite master channels
//
// Every output is a register or a direct copy of a holding register. No
// input has a combinational path to any output.
module axil_master
  import axil_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [MemAddrW-1:0] addr_i,
  input  logic [MemBusW-1:0]  wdata_i,
  input  logic [StrbW-1:0]    sel_i,
  output logic [MemBusW-1:0]  rdata_o,
  output logic                ack_o,
  output logic                err_o,
  output logic                busy_o,
  output logic [MemAddrW-1:0] m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [MemBusW-1:0]  m_axi_wdata,
  output logic [StrbW-1:0]    m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [MemAddrW-1:0] m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [MemBusW-1:0]  m_axi_rdata,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWr   = 3'd1,
    StRdA  = 3'd2,
    StRdD  = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e              state_q;
  logic [MemAddrW-1:0] addr_q;
  logic [MemBusW-1:0]  wdata_q;
  logic [StrbW-1:0]    sel_q;
  logic                we_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic [TO_W-1:0]     to_cnt_q;

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic aw_fin, w_fin;
  logic to_expired;

  always_comb begin
    aw_hs      = m_axi_awvalid & m_axi_awready;
    w_hs       = m_axi_wvalid & m_axi_wready;
    ar_hs      = m_axi_arvalid & m_axi_arready;
    r_hs       = m_axi_rvalid & m_axi_rready;
    // A channel counts as finished if it completed earlier or completes this cycle.
    aw_fin     = aw_done_q | aw_hs;
    w_fin      = w_done_q | w_hs;
    to_expired = (to_cnt_q == TO_W'(TIMEOUT - 1));
  end

  // Address, data and strobes are passed through unmodified from the holding registers.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      sel_q         <= '0;
      we_q          <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      to_cnt_q      <= '0;
      rdata_o       <= '0;
      ack_o         <= 1'b0;
      err_o         <= 1'b0;
      busy_o        <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_i) begin
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            sel_q    <= sel_i;
            we_q     <= we_i;
            to_cnt_q <= '0;
            busy_o   <= 1'b1;
            if (we_i) begin
              state_q       <= StWr;
              aw_done_q     <= 1'b0;
              w_done_q      <= 1'b0;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              state_q       <= StRdA;
              m_axi_arvalid <= 1'b1;
            end
          end
        end

        StWr: begin
          if (aw_fin && w_fin) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            ack_o         <= 1'b1;
            err_o         <= 1'b0;
            state_q       <= StDone;
          end else if (to_expired) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            ack_o         <= 1'b1;
            err_o         <= 1'b1;
            state_q       <= StDone;
          end else begin
            if (aw_hs) begin
              m_axi_awvalid <= 1'b0;
              aw_done_q     <= 1'b1;
            end
            if (w_hs) begin
              m_axi_wvalid <= 1'b0;
              w_done_q     <= 1'b1;
            end
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        StRdA: begin
          if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            to_cnt_q      <= '0;
            state_q       <= StRdD;
          end else if (to_expired) begin
            m_axi_arvalid <= 1'b0;
            rdata_o       <= '0;
            ack_o         <= 1'b1;
            err_o         <= 1'b1;
            state_q       <= StDone;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        StRdD: begin
          if (r_hs) begin
            rdata_o      <= m_axi_rdata;
            m_axi_rready <= 1'b0;
            ack_o        <= 1'b1;
            err_o        <= 1'b0;
            state_q      <= StDone;
          end else if (to_expired) begin
            m_axi_rready <= 1'b0;
            rdata_o      <= '0;
            ack_o        <= 1'b1;
            err_o        <= 1'b1;
            state_q      <= StDone;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        StDone: begin
          ack_o   <= 1'b0;
          err_o   <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= StIdle;
          // A timed-out read leaves rdata_o at zero. Writes leave it untouched.
          if (err_o && !we_q) begin
            rdata_o <= '0;
          end
        end

        default: begin
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b0;
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b0;
          ack_o         <= 1'b0;
          err_o         <= 1'b0;
          busy_o        <= 1'b0;
          state_q       <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master, using TIMEOUT = 8. Inputs change 1 time unit
// after each rising edge. Outputs are checked at the same point in the cycle,
// so each check sees the values registered by the preceding edge.
module tb_axil_master;

  logic        clk;
  logic        rst_n;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  sel_i;
  logic [31:0] rdata_o;
  logic        ack_o, err_o, busy_o;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

  int n_chk = 0;
  int n_bad = 0;

  axil_master #(
    .TIMEOUT(8),
    .TO_W   (16)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .sel_i        (sel_i),
    .rdata_o      (rdata_o),
    .ack_o        (ack_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = data;
    sel_i   = sel;
  endtask

  initial begin
    rst_n = 1'b0;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; sel_i = '0;
    slave_idle();
    step();
    step();
    check("rst_ack", {31'b0, ack_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_valids", {28'b0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready},
          32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    rst_n = 1'b1;
    step();

    // Zero-wait write: handshake at N+1, ack at N+2.
    issue(1'b1, 32'h0000_0400, 32'h0000_00A5, 4'hF);
    step();
    req_i = 1'b0;
    check("wr_awvalid", {31'b0, m_axi_awvalid}, 32'd1);
    check("wr_wvalid", {31'b0, m_axi_wvalid}, 32'd1);
    check("wr_wstrb", {28'b0, m_axi_wstrb}, 32'hF);
    check("wr_awaddr", m_axi_awaddr, 32'h0000_0400);
    check("wr_wdata", m_axi_wdata, 32'h0000_00A5);
    check("wr_busy", {31'b0, busy_o}, 32'd1);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    step();
    slave_idle();
    check("wr_ack", {31'b0, ack_o}, 32'd1);
    check("wr_err", {31'b0, err_o}, 32'd0);
    check("wr_valids_low", {30'b0, m_axi_awvalid, m_axi_wvalid}, 32'd0);
    step();
    check("wr_ack_pulse", {31'b0, ack_o}, 32'd0);
    check("wr_idle", {31'b0, busy_o}, 32'd0);

    // Zero-wait read: AR at N+1, R at N+2, ack at N+3.
    issue(1'b0, 32'h0000_0404, 32'h0, 4'h0);
    step();
    req_i = 1'b0;
    check("rd_arvalid", {31'b0, m_axi_arvalid}, 32'd1);
    check("rd_araddr", m_axi_araddr, 32'h0000_0404);
    check("rd_rready_early", {31'b0, m_axi_rready}, 32'd0);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    check("rd_arvalid_drop", {31'b0, m_axi_arvalid}, 32'd0);
    check("rd_rready", {31'b0, m_axi_rready}, 32'd1);
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678;
    step();
    slave_idle();
    check("rd_ack", {31'b0, ack_o}, 32'd1);
    check("rd_err", {31'b0, err_o}, 32'd0);
    check("rd_rdata", rdata_o, 32'h1234_5678);
    check("rd_rready_drop", {31'b0, m_axi_rready}, 32'd0);
    step();
    check("rd_rdata_hold", rdata_o, 32'h1234_5678);

    // Skewed write: awready at N+1, wready at N+4, ack at N+5.
    issue(1'b1, 32'h0000_0408, 32'hDEAD_BEEF, 4'h3);
    step();
    req_i = 1'b0;
    m_axi_awready = 1'b1;
    step();
    m_axi_awready = 1'b0;
    check("sk_aw_drop", {31'b0, m_axi_awvalid}, 32'd0);
    check("sk_w_held2", {31'b0, m_axi_wvalid}, 32'd1);
    step();
    check("sk_w_held3", {31'b0, m_axi_wvalid}, 32'd1);
    check("sk_no_ack3", {31'b0, ack_o}, 32'd0);
    check("sk_aw_low3", {31'b0, m_axi_awvalid}, 32'd0);
    step();
    check("sk_w_held4", {31'b0, m_axi_wvalid}, 32'd1);
    check("sk_wstrb", {28'b0, m_axi_wstrb}, 32'h3);
    m_axi_wready = 1'b1;
    step();
    slave_idle();
    check("sk_ack", {31'b0, ack_o}, 32'd1);
    check("sk_w_drop", {31'b0, m_axi_wvalid}, 32'd0);
    step();
    check("sk_single_ack", {31'b0, ack_o}, 32'd0);

    // Hung read: arvalid for 8 cycles, then an error acknowledge.
    issue(1'b0, 32'h0000_0500, 32'h0, 4'h0);
    step();
    req_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("hung_arvalid_%0d", i), {31'b0, m_axi_arvalid}, 32'd1);
      check($sformatf("hung_noack_%0d", i), {31'b0, ack_o}, 32'd0);
      step();
    end
    check("hung_ar_drop", {31'b0, m_axi_arvalid}, 32'd0);
    check("hung_ack", {31'b0, ack_o}, 32'd1);
    check("hung_err", {31'b0, err_o}, 32'd1);
    check("hung_rdata", rdata_o, 32'd0);
    step();
    check("hung_ack_pulse", {30'b0, ack_o, err_o}, 32'd0);
    check("hung_idle", {31'b0, busy_o}, 32'd0);
    // A new request after the timeout is accepted.
    issue(1'b0, 32'h0000_0404, 32'h0, 4'h0);
    step();
    req_i = 1'b0;
    check("post_arvalid", {31'b0, m_axi_arvalid}, 32'd1);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hCAFE_F00D;
    step();
    slave_idle();
    check("post_ack", {30'b0, ack_o, err_o}, 32'd2);
    check("post_rdata", rdata_o, 32'hCAFE_F00D);
    step();

    // Reset in the data phase of a read.
    issue(1'b0, 32'h0000_0404, 32'h0, 4'h0);
    step();
    req_i = 1'b0;
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    check("mr_rready", {31'b0, m_axi_rready}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_rready_async", {31'b0, m_axi_rready}, 32'd0);
    check("mr_arvalid_async", {31'b0, m_axi_arvalid}, 32'd0);
    check("mr_busy_async", {31'b0, busy_o}, 32'd0);
    step();
    rst_n = 1'b1;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mr_no_ack_%0d", i), {29'b0, ack_o, busy_o, m_axi_rready}, 32'd0);
    end
    slave_idle();

    // Back-to-back: req held through a read and then a write.
    issue(1'b0, 32'h0000_0404, 32'h0, 4'h0);
    step();
    check("bb_arvalid", {31'b0, m_axi_arvalid}, 32'd1);
    // Ignored while busy, then sampled in the idle cycle.
    we_i = 1'b1; addr_i = 32'h0000_0410; wdata_i = 32'h0000_0077; sel_i = 4'h1;
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    check("bb_no_aw", {31'b0, m_axi_awvalid}, 32'd0);
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0BAD_BEEF;
    step();
    slave_idle();
    check("bb_rd_ack", {31'b0, ack_o}, 32'd1);
    check("bb_rd_busy", {31'b0, busy_o}, 32'd1);
    check("bb_rd_rdata", rdata_o, 32'h0BAD_BEEF);
    step();
    check("bb_gap_ack", {31'b0, ack_o}, 32'd0);
    check("bb_gap_busy", {31'b0, busy_o}, 32'd0);
    step();
    req_i = 1'b0;
    check("bb_wr_busy", {31'b0, busy_o}, 32'd1);
    check("bb_wr_valids", {30'b0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
    check("bb_wr_addr", m_axi_awaddr, 32'h0000_0410);
    check("bb_wr_ack_low", {31'b0, ack_o}, 32'd0);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    step();
    slave_idle();
    check("bb_wr_ack", {30'b0, ack_o, err_o}, 32'd2);
    step();
    check("bb_end_idle", {30'b0, ack_o, busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
